// File: rtl/locked_reg_pkg.sv
// Shared types and constants for the lockable register read path.
// Imported by the interface-facing top and its sub-modules.
package locked_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int DEF_NREGS = 4;
    localparam int DEF_DW    = 16;
    localparam int DEF_CNT_W = 8;

    // Data returned in place of a protected register's contents
    localparam logic [DEF_DW-1:0] ZERO_DATA = 16'h0000;

endpackage

// File: rtl/locked_reg_reader_if.sv
// Read request/response handshake between a requester and locked_reg_reader.
interface locked_reg_reader_if #(
    parameter int AW = 2,
    parameter int DW = 16
);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          rsp_ready;

    modport master (
        output rd_req,
        output rd_addr,
        output rsp_ready,
        input  rd_ready,
        input  rd_valid,
        input  rd_data,
        input  rd_err
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        input  rsp_ready,
        output rd_ready,
        output rd_valid,
        output rd_data,
        output rd_err
    );
endinterface

// File: rtl/violation_counter.sv
// Saturating event counter with a one-cycle registered pulse per event.
// Generic enough to be shared with write-side audit logic.
module violation_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hit,
    output logic             pulse,
    output logic [CNT_W-1:0] count
);

    logic             pulse_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    // Next count: increment on a hit, hold once the counter is full
    always_comb begin
        count_nxt_s = count_r;
        if (hit && (count_r != {CNT_W{1'b1}})) begin
            count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pulse and count registers; pulse fires even when the count is saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_r <= 1'b0;
            count_r <= {CNT_W{1'b0}};
        end else begin
            pulse_r <= hit;
            count_r <= count_nxt_s;
        end
    end

    assign pulse = pulse_r;
    assign count = count_r;

endmodule

// File: rtl/locked_reg_reader.sv
// Read-side responder for a bank of lockable configuration registers.
// Denies reads of locked, read-protected registers and reports each denial.
module locked_reg_reader
    import locked_reg_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int DW    = DEF_DW,
    parameter int AW    = $clog2(NREGS),
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                Clk,
    input  logic                resetn,
    input  logic [NREGS*DW-1:0] reg_data,
    input  logic [NREGS-1:0]    lock_status,
    input  logic [NREGS-1:0]    read_protect,
    input  logic                scan_mode,
    input  logic                debug_unlocked,
    locked_reg_reader_if.slave  rd_if,
    output logic                violation_pulse,
    output logic [CNT_W-1:0]    violation_count
);

    state_e         state_r;
    logic [AW-1:0]  addr_r;
    logic           rd_ready_r;
    logic           rd_valid_r;
    logic [DW-1:0]  rd_data_r;
    logic           rd_err_r;

    logic           deny_s;
    logic [DW-1:0]  sel_data_s;
    logic           hit_s;
    logic           ovr_unused_s;

    // Override indicators are deliberately kept out of the access decision
    assign ovr_unused_s = scan_mode ^ debug_unlocked;

    // Deny decision and data select; protected data never reaches the mux output
    always_comb begin
        deny_s     = 1'b0;
        sel_data_s = DW'(ZERO_DATA);
        hit_s      = 1'b0;
        if (lock_status[addr_r] && read_protect[addr_r]) begin
            deny_s = 1'b1;
        end else begin
            deny_s = 1'b0;
        end
        if (deny_s) begin
            sel_data_s = DW'(ZERO_DATA);
        end else begin
            sel_data_s = reg_data[addr_r*DW +: DW];
        end
        if (state_r == CHECK) begin
            hit_s = deny_s;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Request FSM with registered handshake and response outputs
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            addr_r     <= {AW{1'b0}};
            rd_ready_r <= 1'b1;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DW{1'b0}};
            rd_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rd_if.rd_req && rd_ready_r) begin
                        addr_r     <= rd_if.rd_addr;
                        rd_ready_r <= 1'b0;
                        state_r    <= CHECK;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                CHECK: begin
                    rd_valid_r <= 1'b1;
                    rd_data_r  <= sel_data_s;
                    rd_err_r   <= deny_s;
                    state_r    <= RESP;
                end
                RESP: begin
                    if (rd_if.rsp_ready) begin
                        rd_valid_r <= 1'b0;
                        rd_data_r  <= {DW{1'b0}};
                        rd_err_r   <= 1'b0;
                        rd_ready_r <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        state_r    <= RESP;
                    end
                end
                default: begin
                    rd_valid_r <= 1'b0;
                    rd_data_r  <= {DW{1'b0}};
                    rd_err_r   <= 1'b0;
                    rd_ready_r <= 1'b1;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    violation_counter #(
        .CNT_W (CNT_W)
    ) u_violation_counter (
        .clk   (Clk),
        .rst_n (resetn),
        .hit   (hit_s),
        .pulse (violation_pulse),
        .count (violation_count)
    );

    assign rd_if.rd_ready = rd_ready_r;
    assign rd_if.rd_valid = rd_valid_r;
    assign rd_if.rd_data  = rd_data_r;
    assign rd_if.rd_err   = rd_err_r;

endmodule

// File: tb/tb_locked_reg_reader.sv
// Bench for locked_reg_reader: two instances (8-bit and 2-bit counters) share
// stimulus; responses are compared against a register-bank model.
module tb_locked_reg_reader;

    logic        clk;
    logic        resetn;
    logic [15:0] regs [4];
    logic [3:0]  lock;
    logic [3:0]  prot;
    logic        scan_mode;
    logic        debug_unlocked;
    logic        rd_req;
    logic [1:0]  rd_addr;
    logic        rsp_ready;
    logic [63:0] reg_data;

    logic        pulse8;
    logic [7:0]  count8;
    logic        pulse2;
    logic [1:0]  count2;

    int n_tests;
    int n_fail;
    int exp_cnt8;
    int exp_cnt2;

    locked_reg_reader_if #(.AW(2), .DW(16)) if8 ();
    locked_reg_reader_if #(.AW(2), .DW(16)) if2 ();

    assign reg_data      = {regs[3], regs[2], regs[1], regs[0]};
    assign if8.rd_req    = rd_req;
    assign if8.rd_addr   = rd_addr;
    assign if8.rsp_ready = rsp_ready;
    assign if2.rd_req    = rd_req;
    assign if2.rd_addr   = rd_addr;
    assign if2.rsp_ready = rsp_ready;

    locked_reg_reader #(.NREGS(4), .DW(16), .AW(2), .CNT_W(8)) dut8 (
        .Clk             (clk),
        .resetn          (resetn),
        .reg_data        (reg_data),
        .lock_status     (lock),
        .read_protect    (prot),
        .scan_mode       (scan_mode),
        .debug_unlocked  (debug_unlocked),
        .rd_if           (if8),
        .violation_pulse (pulse8),
        .violation_count (count8)
    );

    locked_reg_reader #(.NREGS(4), .DW(16), .AW(2), .CNT_W(2)) dut2 (
        .Clk             (clk),
        .resetn          (resetn),
        .reg_data        (reg_data),
        .lock_status     (lock),
        .read_protect    (prot),
        .scan_mode       (scan_mode),
        .debug_unlocked  (debug_unlocked),
        .rd_if           (if2),
        .violation_pulse (pulse2),
        .violation_count (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Idle response outputs and counters on both instances
    task automatic check_idle(input string tag);
        check_val({tag, "_ready"}, {31'd0, if8.rd_ready}, 32'd1);
        check_val({tag, "_valid"}, {31'd0, if8.rd_valid}, 32'd0);
        check_val({tag, "_data"},  {16'd0, if8.rd_data},  32'd0);
        check_val({tag, "_err"},   {31'd0, if8.rd_err},   32'd0);
        check_val({tag, "_valid2"}, {31'd0, if2.rd_valid}, 32'd0);
        check_val({tag, "_cnt8"},  {24'd0, count8}, exp_cnt8);
        check_val({tag, "_cnt2"},  {30'd0, count2}, exp_cnt2);
    endtask

    // One full read transaction; all driving and sampling on negedge
    task automatic do_read(input logic [1:0] a, input int hold, input bit chg_check);
        int          waitc;
        bit          deny;
        logic [15:0] expd;
        logic [15:0] held;
        waitc = 0;
        while (!if8.rd_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check_val("ready_before_req", {31'd0, if8.rd_ready}, 32'd1);
        rsp_ready = (hold == 0);
        rd_req    = 1'b1;
        rd_addr   = a;
        @(negedge clk);
        rd_req = 1'b0;
        check_val("ready_in_check", {31'd0, if8.rd_ready}, 32'd0);
        check_val("valid_in_check", {31'd0, if8.rd_valid}, 32'd0);
        if (chg_check) begin
            lock[a] = ~lock[a];
            prot[a] = 1'b1;
            regs[a] = 16'($urandom);
        end
        deny = lock[a] && prot[a];
        expd = deny ? 16'h0000 : regs[a];
        if (deny) begin
            exp_cnt8 = (exp_cnt8 < 255) ? exp_cnt8 + 1 : 255;
            exp_cnt2 = (exp_cnt2 < 3) ? exp_cnt2 + 1 : 3;
        end
        @(negedge clk);
        check_val("rsp_valid",  {31'd0, if8.rd_valid}, 32'd1);
        check_val("rsp_data",   {16'd0, if8.rd_data},  {16'd0, expd});
        check_val("rsp_err",    {31'd0, if8.rd_err},   {31'd0, deny});
        check_val("rsp_data2",  {16'd0, if2.rd_data},  {16'd0, expd});
        check_val("pulse8",     {31'd0, pulse8},       {31'd0, deny});
        check_val("pulse2",     {31'd0, pulse2},       {31'd0, deny});
        check_val("cnt8",       {24'd0, count8},       exp_cnt8);
        check_val("cnt2",       {30'd0, count2},       exp_cnt2);
        held = if8.rd_data;
        for (int i = 0; i < hold; i++) begin
            regs[a]   = 16'($urandom);
            lock      = 4'($urandom);
            rd_req    = 1'b1;
            rd_addr   = 2'($urandom);
            @(negedge clk);
            check_val("hold_valid", {31'd0, if8.rd_valid}, 32'd1);
            check_val("hold_data",  {16'd0, if8.rd_data},  {16'd0, expd});
            check_val("hold_err",   {31'd0, if8.rd_err},   {31'd0, deny});
            check_val("hold_ready", {31'd0, if8.rd_ready}, 32'd0);
            check_val("hold_pulse", {31'd0, pulse8},       32'd0);
        end
        rd_req    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_idle("release");
        check_val("release_pulse", {31'd0, pulse8}, 32'd0);
        if (held !== expd) begin
            check_val("held_snapshot", {16'd0, held}, {16'd0, expd});
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        exp_cnt8       = 0;
        exp_cnt2       = 0;
        resetn         = 1'b0;
        rd_req         = 1'b0;
        rd_addr        = 2'd0;
        rsp_ready      = 1'b1;
        scan_mode      = 1'b0;
        debug_unlocked = 1'b0;
        lock           = 4'h0;
        prot           = 4'h0;
        for (int i = 0; i < 4; i++) regs[i] = 16'h0000;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check_val("reset_pulse", {31'd0, pulse8}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Unlocked read
        regs[2] = 16'hBEEF;
        do_read(2'd2, 0, 1'b0);

        // Locked protected read
        regs[1] = 16'h1234;
        lock[1] = 1'b1;
        prot[1] = 1'b1;
        do_read(2'd1, 0, 1'b0);

        // Override indicators do not grant access
        scan_mode      = 1'b1;
        debug_unlocked = 1'b1;
        do_read(2'd1, 0, 1'b0);
        scan_mode      = 1'b0;
        debug_unlocked = 1'b0;

        // Backpressure with changing inputs
        lock = 4'h0;
        regs[3] = 16'hA5A5;
        do_read(2'd3, 5, 1'b0);
        lock = 4'hF;
        prot = 4'hF;
        do_read(2'd0, 5, 1'b0);

        // Reset during CHECK drops the in-flight request
        rd_req  = 1'b1;
        rd_addr = 2'd1;
        @(negedge clk);
        rd_req   = 1'b0;
        resetn   = 1'b0;
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("post_reset");
            check_val("post_reset_pulse", {31'd0, pulse8}, 32'd0);
        end

        // Saturation of the 2-bit counter: five denied reads
        lock = 4'hF;
        prot = 4'hF;
        for (int i = 0; i < 5; i++) begin
            do_read(2'($urandom), 0, 1'b0);
        end
        check_val("sat_cnt2", {30'd0, count2}, 32'd3);
        check_val("sat_cnt8", {24'd0, count8}, 32'd5);

        // Randomized reads, including lock toggles during CHECK
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 4; i++) regs[i] = 16'($urandom);
            lock           = 4'($urandom);
            prot           = 4'($urandom);
            scan_mode      = 1'($urandom);
            debug_unlocked = 1'($urandom);
            do_read(2'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
